// File: rtl/arith_sequencer.sv
// Multi-cycle unsigned arithmetic sequencer: one-cycle add/subtract, and
// multiply/divide that take one operand bit per cycle.
//
// state  | meaning
// IDLE   | waiting for start; operands latched on acceptance
// RUN    | computing; 1 cycle for add/sub/div-by-zero, W cycles for mul/div
// DONE   | result valid, done pulse, start ignored
module arith_sequencer #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [1:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] result,
   output logic           flag,
   output logic           busy,
   output logic           done
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   logic [1:0]     state_q, state_d;
   logic [1:0]     op_q, op_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [2*W-1:0] m_q, m_d;
   logic [2*W-1:0] p_q, p_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] result_q, result_d;
   logic           flag_q, flag_d;

   logic [W:0]     sum_w;
   logic [W:0]     diff_w;
   logic [2*W-1:0] prod_next;
   logic [W:0]     trial;
   logic [W:0]     trial_sub;
   logic           q_bit;
   logic [W-1:0]   rem_next;
   logic [W-1:0]   quo_next;

   always_comb begin
      sum_w     = {1'b0, a_q} + {1'b0, b_q};
      diff_w    = {1'b0, a_q} + {1'b0, ~b_q} + {{W{1'b0}}, 1'b1};
      prod_next = p_q + (b_q[0] ? m_q : '0);
      // Restoring step: a set bit W in trial_sub means the trial went negative.
      trial     = {p_q[W-1:0], a_q[W-1]};
      trial_sub = trial - {1'b0, b_q};
      q_bit     = ~trial_sub[W];
      rem_next  = q_bit ? trial_sub[W-1:0] : trial[W-1:0];
      quo_next  = {a_q[W-2:0], q_bit};
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      m_d      = m_q;
      p_d      = p_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      flag_d   = flag_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               a_d     = a;
               b_d     = b;
               m_d     = {{W{1'b0}}, a};
               p_d     = '0;
               cnt_d   = CW'(W - 1);
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            case (op_q)
               OP_ADD: begin
                  result_d = {{W{1'b0}}, sum_w[W-1:0]};
                  flag_d   = sum_w[W];
                  state_d  = S_DONE;
               end
               OP_SUB: begin
                  result_d = {{W{1'b0}}, diff_w[W-1:0]};
                  flag_d   = ~diff_w[W];
                  state_d  = S_DONE;
               end
               OP_MUL: begin
                  p_d = prod_next;
                  m_d = {m_q[2*W-2:0], 1'b0};
                  b_d = {1'b0, b_q[W-1:1]};
                  if (cnt_q == '0) begin
                     result_d = prod_next;
                     flag_d   = 1'b0;
                     state_d  = S_DONE;
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
               OP_DIV: begin
                  if (b_q == '0) begin
                     result_d = {a_q, {W{1'b1}}};
                     flag_d   = 1'b1;
                     state_d  = S_DONE;
                  end else begin
                     a_d = quo_next;
                     p_d = {{W{1'b0}}, rem_next};
                     if (cnt_q == '0) begin
                        result_d = {rem_next, quo_next};
                        flag_d   = 1'b0;
                        state_d  = S_DONE;
                     end else begin
                        cnt_d = cnt_q - 1'b1;
                     end
                  end
               end
               default: state_d = S_DONE;
            endcase
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         p_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         flag_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         m_q      <= m_d;
         p_q      <= p_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         flag_q   <= flag_d;
      end
   end

   assign result = result_q;
   assign flag   = flag_q;
   assign busy   = (state_q != S_IDLE);
   assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_arith_sequencer.sv
// Self-checking bench for arith_sequencer: directed cases plus random
// operations checked against a plain-arithmetic reference model.
module tb_arith_sequencer;

   localparam int W = 4;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [1:0]     op;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [2*W-1:0] result;
   logic           flag;
   logic           busy;
   logic           done;

   int n_chk  = 0;
   int n_fail = 0;

   arith_sequencer #(.W(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .result (result),
      .flag   (flag),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference model straight from the arithmetic definitions.
   task automatic model(input int o, input int av, input int bv,
                        output int res, output int flg, output int lat);
      int m;
      m = 1 << W;
      case (o)
         0: begin res = (av + bv) % m;     flg = ((av + bv) >= m) ? 1 : 0; lat = 1; end
         1: begin res = (av - bv + m) % m; flg = (av < bv) ? 1 : 0;        lat = 1; end
         2: begin res = av * bv;           flg = 0;                        lat = W; end
         default: begin
            if (bv == 0) begin res = av * m + (m - 1); flg = 1; lat = 1; end
            else begin res = (av % bv) * m + (av / bv); flg = 0; lat = W; end
         end
      endcase
   endtask

   // Called at #1 after an edge while IDLE. Optionally disturbs inputs mid-run.
   task automatic run_op(input string tag, input int o, input int av, input int bv,
                         input int exp_res, input int exp_flg, input int exp_lat,
                         input bit disturb);
      int k;
      start = 1'b1; op = 2'(o); a = W'(av); b = W'(bv);
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (k < 20) begin
         chk({tag, " busy"}, 16'(busy), 16'd1);
         @(posedge clk); #1;
         k++;
         if (disturb && k == 1) begin
            start = 1'b1; op = 2'(o ^ 1); a = W'($urandom); b = W'($urandom);
         end
         if (disturb && k == 2) start = 1'b0;
         if (done) break;
      end
      chk({tag, " latency"}, 16'(k), 16'(exp_lat));
      chk({tag, " result"}, 16'(result), 16'(exp_res));
      chk({tag, " flag"}, 16'(flag), 16'(exp_flg));
      chk({tag, " busy in done"}, 16'(busy), 16'd1);
      @(posedge clk); #1;
      chk({tag, " done width"}, 16'(done), 16'd0);
      chk({tag, " idle"}, 16'(busy), 16'd0);
      chk({tag, " hold"}, 16'(result), 16'(exp_res));
   endtask

   initial begin
      int r, f, l, o, av, bv;
      rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst result", 16'(result), 16'd0);
      chk("rst flag", 16'(flag), 16'd0);
      chk("rst busy", 16'(busy), 16'd0);
      chk("rst done", 16'(done), 16'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("add 9+8", 0, 9, 8, 'h01, 1, 1, 1'b0);
      run_op("sub 3-5", 1, 3, 5, 'h0E, 1, 1, 1'b0);
      run_op("sub 5-3", 1, 5, 3, 'h02, 0, 1, 1'b0);
      run_op("mul 15*15", 2, 15, 15, 'hE1, 0, 4, 1'b0);
      run_op("div 13/4", 3, 13, 4, 'h13, 0, 4, 1'b0);
      run_op("div 7/0", 3, 7, 0, 'h7F, 1, 1, 1'b0);
      run_op("mul ignore start", 2, 11, 13, 143, 0, 4, 1'b1);

      // Reset during cycle 2 of a multiply.
      start = 1'b1; op = 2'd2; a = 4'd15; b = 4'd15;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort result", 16'(result), 16'd0);
      chk("abort flag", 16'(flag), 16'd0);
      chk("abort busy", 16'(busy), 16'd0);
      chk("abort done", 16'(done), 16'd0);
      @(posedge clk); #1;
      chk("abort done held", 16'(done), 16'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("after rst done", 16'(done), 16'd0);
      chk("after rst busy", 16'(busy), 16'd0);
      run_op("add 1+1", 0, 1, 1, 'h02, 0, 1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         o  = int'($urandom_range(0, 3));
         av = int'($urandom_range(0, 15));
         bv = (i % 8 == 0) ? 0 : int'($urandom_range(0, 15));
         model(o, av, bv, r, f, l);
         run_op($sformatf("rnd%0d op%0d %0d,%0d", i, o, av, bv), o, av, bv, r, f, l, (i % 5 == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
